// File: rtl/icache_fa_mt.sv
// Fully-associative, physically-tagged instruction cache for the multithreaded fetch stage.
// A hit returns the line in the request cycle. A miss blocks only the requesting thread until its refill returns.
module icache_fa_mt #(
    parameter int unsigned THR_PER_CORE   = 4,
    parameter int unsigned THR_ID_WIDTH   = 2,
    parameter int unsigned PHY_ADDR_WIDTH = 20,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned NUM_LINES      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mt_mode,
    input  logic                      req_valid,
    input  logic [PHY_ADDR_WIDTH-1:0] req_addr,
    input  logic [THR_ID_WIDTH-1:0]   req_thread_id,
    output logic [THR_PER_CORE-1:0]   icache_ready,
    output logic                      rsp_valid,
    output logic [LINE_WIDTH-1:0]     rsp_data,
    output logic                      xcpt_bus_error,
    output logic                      req_valid_miss,
    output logic [PHY_ADDR_WIDTH-1:0] req_miss_addr,
    output logic [THR_ID_WIDTH-1:0]   req_miss_thread_id,
    input  logic                      rsp_valid_miss,
    input  logic [THR_ID_WIDTH-1:0]   rsp_thread_id,
    input  logic [LINE_WIDTH-1:0]     rsp_data_miss,
    input  logic                      rsp_bus_error
);

    localparam int unsigned OFF_W = 4;
    localparam int unsigned TAG_W = PHY_ADDR_WIDTH - OFF_W;
    localparam int unsigned IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic [NUM_LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]          tag_q  [NUM_LINES];
    logic [LINE_WIDTH-1:0]     data_q [NUM_LINES];
    logic [IDX_W-1:0]          victim_q, victim_d;
    logic [THR_PER_CORE-1:0]   pending_q, pending_d;
    logic [TAG_W-1:0]          pend_tag_q [THR_PER_CORE];
    logic                      miss_valid_q;
    logic [PHY_ADDR_WIDTH-1:0] miss_addr_q;
    logic [THR_ID_WIDTH-1:0]   miss_tid_q;
    logic                      xcpt_q;

    logic [TAG_W-1:0]          req_tag_c;
    logic                      accept_c, hit_c, miss_c;
    logic [LINE_WIDTH-1:0]     hit_data_c;
    logic                      fill_c, fill_ok_c;
    logic [TAG_W-1:0]          fill_tag_c;
    logic                      match_found_c, inval_found_c, use_victim_c;
    logic [IDX_W-1:0]          match_idx_c, inval_idx_c, fill_idx_c;
    logic                      unused_c;

    // mt_mode and the line offset do not affect lookup or refill
    assign unused_c  = ^{mt_mode, req_addr[OFF_W-1:0]};
    assign req_tag_c = req_addr[PHY_ADDR_WIDTH-1:OFF_W];
    assign accept_c  = req_valid && !pending_q[req_thread_id];

    // Tag lookup against every valid entry, using pre-fill contents
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag_c)) begin
                hit_c      = 1'b1;
                hit_data_c = data_q[i];
            end
        end
    end

    assign miss_c    = accept_c && !hit_c;
    assign rsp_valid = accept_c && hit_c;
    assign rsp_data  = hit_data_c;

    assign fill_c     = rsp_valid_miss && pending_q[rsp_thread_id];
    assign fill_ok_c  = fill_c && !rsp_bus_error;
    assign fill_tag_c = pend_tag_q[rsp_thread_id];

    // Install slot: existing copy of the tag, else lowest invalid entry, else victim
    always_comb begin
        match_found_c = 1'b0;
        match_idx_c   = '0;
        inval_found_c = 1'b0;
        inval_idx_c   = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (!match_found_c && valid_q[i] && (tag_q[i] == fill_tag_c)) begin
                match_found_c = 1'b1;
                match_idx_c   = IDX_W'(i);
            end
            if (!inval_found_c && !valid_q[i]) begin
                inval_found_c = 1'b1;
                inval_idx_c   = IDX_W'(i);
            end
        end
        use_victim_c = !match_found_c && !inval_found_c;
        if (match_found_c) begin
            fill_idx_c = match_idx_c;
        end else if (inval_found_c) begin
            fill_idx_c = inval_idx_c;
        end else begin
            fill_idx_c = victim_q;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        victim_d  = victim_q;
        pending_d = pending_q;
        if (fill_ok_c) begin
            valid_d[fill_idx_c] = 1'b1;
            if (use_victim_c) begin
                victim_d = victim_q + IDX_W'(1);
            end
        end
        if (fill_c) begin
            pending_d[rsp_thread_id] = 1'b0;
        end
        if (miss_c) begin
            pending_d[req_thread_id] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            victim_q     <= '0;
            pending_q    <= '0;
            miss_valid_q <= 1'b0;
            miss_addr_q  <= '0;
            miss_tid_q   <= '0;
            xcpt_q       <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            victim_q     <= victim_d;
            pending_q    <= pending_d;
            miss_valid_q <= miss_c;
            xcpt_q       <= fill_c && rsp_bus_error;
            if (miss_c) begin
                miss_addr_q <= {req_tag_c, OFF_W'(0)};
                miss_tid_q  <= req_thread_id;
            end
        end
    end

    // Payload storage is qualified by valid/pending bits, so it needs no reset
    always_ff @(posedge clock) begin
        if (fill_ok_c) begin
            tag_q[fill_idx_c]  <= fill_tag_c;
            data_q[fill_idx_c] <= rsp_data_miss;
        end
        if (miss_c) begin
            pend_tag_q[req_thread_id] <= req_tag_c;
        end
    end

    assign icache_ready       = ~pending_q;
    assign req_valid_miss     = miss_valid_q;
    assign req_miss_addr      = miss_addr_q;
    assign req_miss_thread_id = miss_tid_q;
    assign xcpt_bus_error     = xcpt_q;

endmodule

// File: tb/tb_icache_fa_mt.sv
// Scoreboard bench for icache_fa_mt: a line-level reference model predicts each cycle's outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_icache_fa_mt;

    logic         clock = 1'b0;
    logic         reset;
    logic         mt_mode;
    logic         req_valid;
    logic [19:0]  req_addr;
    logic [1:0]   req_thread_id;
    logic [3:0]   icache_ready;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         xcpt_bus_error;
    logic         req_valid_miss;
    logic [19:0]  req_miss_addr;
    logic [1:0]   req_miss_thread_id;
    logic         rsp_valid_miss;
    logic [1:0]   rsp_thread_id;
    logic [127:0] rsp_data_miss;
    logic         rsp_bus_error;

    icache_fa_mt dut (
        .clock              (clock),
        .reset              (reset),
        .mt_mode            (mt_mode),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_thread_id      (req_thread_id),
        .icache_ready       (icache_ready),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .xcpt_bus_error     (xcpt_bus_error),
        .req_valid_miss     (req_valid_miss),
        .req_miss_addr      (req_miss_addr),
        .req_miss_thread_id (req_miss_thread_id),
        .rsp_valid_miss     (rsp_valid_miss),
        .rsp_thread_id      (rsp_thread_id),
        .rsp_data_miss      (rsp_data_miss),
        .rsp_bus_error      (rsp_bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           chk;
        logic [3:0]   rdy;
        logic         rv;
        logic [127:0] rd;
        logic         xc;
        logic         mv;
        logic [19:0]  ma;
        logic [1:0]   mt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: cache contents as line numbers, FIFO victim, per-thread pending line
    bit           m_known = 0;
    bit           m_valid [4];
    int           m_line  [4];
    logic [127:0] m_data  [4];
    int           m_victim;
    bit           m_pend  [4];
    int           m_pline [4];
    bit           m_mv, m_xc;
    int           m_ma, m_mt;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_pend[i]  = 0;
        end
        m_victim = 0;
        m_mv = 0; m_xc = 0; m_ma = 0; m_mt = 0;
        m_known = 1;
    endfunction

    function automatic int find_line(input int line);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_line[i] == line) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("icache_ready", 128'(icache_ready), 128'(e.rdy));
                check("rsp_valid", 128'(rsp_valid), 128'(e.rv));
                if (e.rv) check("rsp_data", rsp_data, e.rd);
                check("xcpt_bus_error", 128'(xcpt_bus_error), 128'(e.xc));
                check("req_valid_miss", 128'(req_valid_miss), 128'(e.mv));
                if (e.mv) begin
                    check("req_miss_addr", 128'(req_miss_addr), 128'(e.ma));
                    check("req_miss_thread_id", 128'(req_miss_thread_id), 128'(e.mt));
                end
            end
        end
    end

    // One clock of stimulus: drive, predict this cycle's outputs, then advance the model
    task automatic cyc(input bit rv, input logic [19:0] a, input logic [1:0] t,
                       input bit fv, input logic [1:0] ft, input logic [127:0] fd,
                       input bit fe, input bit rst);
        exp_t e;
        int   line, hit, slot;
        bit   acc, fill;
        @(posedge clock);
        #1;
        reset = rst; req_valid = rv; req_addr = a; req_thread_id = t;
        rsp_valid_miss = fv; rsp_thread_id = ft; rsp_data_miss = fd; rsp_bus_error = fe;
        mt_mode = 1'($urandom);

        line = int'(a) >> 4;
        hit  = find_line(line);
        acc  = rv && !m_pend[t];
        fill = fv && m_pend[ft];
        e.chk = m_known;
        for (int i = 0; i < 4; i++) e.rdy[i] = !m_pend[i];
        e.rv = acc && hit >= 0;
        e.rd = (hit >= 0) ? m_data[hit] : '0;
        e.xc = m_xc; e.mv = m_mv; e.ma = 20'(m_ma); e.mt = 2'(m_mt);
        exp_q.push_back(e);

        if (rst) begin
            model_reset();
        end else if (m_known) begin
            m_xc = fill && fe;
            m_mv = 0;
            if (fill) begin
                if (!fe) begin
                    slot = find_line(m_pline[ft]);
                    if (slot < 0)
                        for (int i = 3; i >= 0; i--) if (!m_valid[i]) slot = i;
                    if (slot < 0) begin
                        slot = m_victim;
                        m_victim = (m_victim + 1) % 4;
                    end
                    m_valid[slot] = 1; m_line[slot] = m_pline[ft]; m_data[slot] = fd;
                end
                m_pend[ft] = 0;
            end
            if (acc && hit < 0) begin
                m_pend[t] = 1; m_pline[t] = line;
                m_mv = 1; m_ma = line << 4; m_mt = int'(t);
            end
        end
    endtask

    task automatic idle();
        cyc(0, 20'h0, 2'd0, 0, 2'd0, 128'h0, 0, 0);
    endtask

    task automatic req(input logic [19:0] a, input logic [1:0] t);
        cyc(1, a, t, 0, 2'd0, 128'h0, 0, 0);
    endtask

    task automatic fill(input logic [1:0] t, input logic [127:0] d, input bit err);
        cyc(0, 20'h0, 2'd0, 1, t, d, err, 0);
    endtask

    task automatic do_reset();
        cyc(0, 20'h0, 2'd0, 0, 2'd0, 128'h0, 0, 1);
    endtask

    initial begin
        logic [19:0]  ra;
        logic [127:0] rd;
        reset = 1; req_valid = 0; req_addr = '0; req_thread_id = '0; mt_mode = 0;
        rsp_valid_miss = 0; rsp_thread_id = '0; rsp_data_miss = '0; rsp_bus_error = 0;

        do_reset(); do_reset();
        // Cold miss, refill, then hit on another offset of the same line
        req(20'h00104, 2'd0); idle();
        fill(2'd0, 128'hDDDD_CCCC_BBBB_AAAA, 0); idle();
        req(20'h0010C, 2'd0); idle();
        // Hit from thread 1 while thread 0 is pending; thread 0 re-request ignored
        req(20'h00200, 2'd0); req(20'h00100, 2'd1); req(20'h00200, 2'd0); idle();
        fill(2'd0, 128'h2222_0000_2222_0000, 0); idle();
        // FIFO replacement after all entries are filled
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            req(20'(i << 12), 2'(i)); idle();
            fill(2'(i), {4{32'(i)}}, 0); idle();
        end
        req(20'h01000, 2'd0); req(20'h02000, 2'd1); idle();
        fill(2'd0, {4{32'h1111_0001}}, 0); idle();
        // Bus error: pulse, thread released, line not installed
        req(20'h00300, 2'd2); idle();
        fill(2'd2, 128'hBAD, 1); idle(); idle();
        req(20'h00300, 2'd2); idle();
        fill(2'd2, 128'h3333, 0); idle();
        // Response for a non-pending thread, then reset mid-miss with a late response
        fill(2'd3, 128'h4444, 0); idle();
        req(20'h00400, 2'd1); idle();
        do_reset(); idle();
        fill(2'd1, 128'h5555, 0); idle();
        req(20'h00400, 2'd1); idle();
        fill(2'd1, 128'h6666, 0); idle();
        req(20'h00400, 2'd2); idle();

        // Random traffic over 8 lines to exercise replacement and concurrent misses
        for (int n = 0; n < 3000; n++) begin
            ra = 20'(($urandom_range(0, 7) << 8) | ($urandom & 15));
            rd = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'($urandom), ra, 2'($urandom), ($urandom % 3) == 0, 2'($urandom),
                rd, ($urandom % 8) == 0, ($urandom % 300) == 0);
        end
        idle(); idle();
        @(negedge clock); #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
